// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader.
// Accepts a framed byte stream (length | data words | XOR checksum), writes
// little-endian 32-bit words to the instruction memory from word 0 upward and
// raises done once the checksum matches, or error on a length/checksum fault.
module imem_boot_loader #(
  parameter int unsigned IMEM_BITS = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [IMEM_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // Capacity in words, widened to 33 bits so a full 32-bit length compares safely.
  localparam logic [32:0] IMEM_SIZE = 33'(1) << IMEM_BITS;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CHK  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           byte_idx, byte_idx_nx;
  logic [7:0]           acc, acc_nx;
  logic [31:0]          shift_buf, shift_buf_nx;
  logic [IMEM_BITS-1:0] last_idx, last_idx_nx;

  logic                 rx_ready_nx;
  logic                 wr_en_nx;
  logic [IMEM_BITS-1:0] wr_addr_nx;
  logic [31:0]          wr_data_nx;
  logic                 busy_nx;
  logic                 done_nx;
  logic                 error_nx;

  logic                 xfer;
  logic [31:0]          assembled;
  logic                 active_nx;

  // State and registered outputs; synchronous active-low reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HDR;
      byte_idx  <= 2'd0;
      acc       <= 8'd0;
      shift_buf <= 32'd0;
      last_idx  <= '0;
      rx_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      byte_idx  <= byte_idx_nx;
      acc       <= acc_nx;
      shift_buf <= shift_buf_nx;
      last_idx  <= last_idx_nx;
      rx_ready  <= rx_ready_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      error     <= error_nx;
    end
  end

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_nx     = state;
    byte_idx_nx  = byte_idx;
    acc_nx       = acc;
    shift_buf_nx = shift_buf;
    last_idx_nx  = last_idx;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = wr_addr;
    wr_data_nx   = wr_data;

    xfer      = rx_valid && rx_ready;
    assembled = {rx_data, shift_buf[31:8]};

    // Step the word address once a strobe has gone out, but never past the last word.
    if (wr_en && (wr_addr != last_idx)) begin
      wr_addr_nx = wr_addr + IMEM_BITS'(1);
    end

    case (state)
      HDR: begin
        if (xfer) begin
          acc_nx       = acc ^ rx_data;
          shift_buf_nx = assembled;
          byte_idx_nx  = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            if ({1'b0, assembled} > IMEM_SIZE) begin
              state_nx = ERR;
            end else if (assembled == 32'd0) begin
              state_nx = CHK;
            end else begin
              last_idx_nx = IMEM_BITS'(assembled - 32'd1);
              state_nx    = DATA;
            end
          end
        end
      end

      DATA: begin
        if (xfer) begin
          acc_nx       = acc ^ rx_data;
          shift_buf_nx = assembled;
          byte_idx_nx  = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            wr_en_nx   = 1'b1;
            wr_data_nx = assembled;
            if (wr_addr == last_idx) begin
              state_nx = CHK;
            end
          end
        end
      end

      CHK: begin
        if (xfer) begin
          state_nx = (rx_data == acc) ? DONE : ERR;
        end
      end

      DONE: state_nx = DONE;

      ERR: state_nx = ERR;

      default: state_nx = ERR;
    endcase

    active_nx   = (state_nx == HDR) || (state_nx == DATA) || (state_nx == CHK);
    rx_ready_nx = active_nx;
    busy_nx     = active_nx;
    done_nx     = (state_nx == DONE);
    error_nx    = (state_nx == ERR);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame scenarios with hand-computed results.
module tb_imem_boot_loader;

  localparam int unsigned IMEM_BITS = 19;

  logic                 clk;
  logic                 reset;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 wr_en;
  logic [IMEM_BITS-1:0] wr_addr;
  logic [31:0]          wr_data;
  logic                 busy;
  logic                 done;
  logic                 error;

  int checks = 0;
  int errors = 0;

  // Write-port log filled by the monitor.
  logic [IMEM_BITS-1:0] wa_q[$];
  logic [31:0]          wd_q[$];
  int                   run_len = 0;
  int                   max_run = 0;

  imem_boot_loader #(.IMEM_BITS(IMEM_BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe and the longest run of consecutive strobe cycles.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // Called at a negedge; the byte transfers on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, wr_en, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {rx_ready, wr_en, busy, done, error});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr %h data %h expected 0 0", wr_addr, wr_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got ready %b busy %b expected 1 1", rx_ready, busy);
    end
    wa_q.delete();
    wd_q.delete();
    max_run = 0;
  endtask

  task automatic test_single_word;
    logic [7:0] frame [9] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    test_reset();
    foreach (frame[i]) send_byte(frame[i]);
    idle(2);
    checks++;
    if (wa_q.size() !== 1) begin
      errors++;
      $display("FAIL single_wr_count: got %0d expected 1", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== '0 || wd_q[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL single_wr: got addr %h data %h expected 0 12345678", wa_q[0], wd_q[0]);
      end
    end
    checks++;
    if ({done, busy, rx_ready, error} !== 4'b1000) begin
      errors++;
      $display("FAIL single_done: got done/busy/ready/err %b expected 1000", {done, busy, rx_ready, error});
    end
  endtask

  task automatic test_gapped_words;
    logic [31:0] exp_d [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    test_reset();
    send_byte(8'h03); idle(1);
    send_byte(8'h00); send_byte(8'h00); idle(3);
    send_byte(8'h00);
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(8'(exp_d[w]));
        if (b == 1) idle(2);
      end
      if (w == 0) begin
        @(negedge clk);
        checks++;
        if (wr_addr !== IMEM_BITS'(1)) begin
          errors++;
          $display("FAIL gap_addr_advance: got %h expected 1", wr_addr);
        end
      end
      idle(w + 1);
    end
    // XOR of header 03 with words whose four bytes cancel.
    send_byte(8'h03);
    idle(1);
    checks++;
    if (wa_q.size() !== 3) begin
      errors++;
      $display("FAIL gap_wr_count: got %0d expected 3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa_q[i] !== IMEM_BITS'(i) || wd_q[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL gap_wr%0d: got addr %h data %h expected %h %h", i, wa_q[i], wd_q[i], i, exp_d[i]);
        end
      end
    end
    checks++;
    if (max_run !== 1) begin
      errors++;
      $display("FAIL gap_strobe_width: got %0d expected 1", max_run);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL gap_done: got done %b error %b expected 1 0", done, error);
    end
  endtask

  task automatic test_length_limit;
    // N = IMEM_SIZE + 1 = 0x00080001 is rejected on the 4th header byte.
    test_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    checks++;
    if ({error, done, busy, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL oversize: got err/done/busy/ready %b expected 1000", {error, done, busy, rx_ready});
    end
    for (int i = 0; i < 6; i++) send_byte(8'hA5);
    idle(2);
    checks++;
    if (wa_q.size() !== 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL oversize_no_write: got writes %0d error %b expected 0 1", wa_q.size(), error);
    end
    // N = IMEM_SIZE exactly is accepted and the loader keeps collecting data.
    test_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    checks++;
    if ({error, busy, rx_ready} !== 3'b011) begin
      errors++;
      $display("FAIL max_len_accept: got err/busy/ready %b expected 011", {error, busy, rx_ready});
    end
  endtask

  task automatic test_empty_and_bad_chk;
    test_reset();
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    idle(1);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wa_q.size() !== 0) begin
      errors++;
      $display("FAIL empty_frame: got done %b error %b writes %0d expected 1 0 0", done, error, wa_q.size());
    end
    // Correct checksum would be 01^AA^BB^CC^DD = 01; send 00 instead.
    test_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h00);
    idle(1);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk: got error %b done %b ready %b expected 1 0 0", error, done, rx_ready);
    end
    checks++;
    if (wa_q.size() !== 1 || wd_q[0] !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL bad_chk_write: got writes %0d data %h expected 1 ddccbbaa", wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'h0);
    end
  endtask

  task automatic test_abort_reload;
    test_reset();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
    idle(1);
    checks++;
    if (wa_q.size() !== 2) begin
      errors++;
      $display("FAIL abort_pre_writes: got %0d expected 2", wa_q.size());
    end
    test_reset();
    // chk = 01^0D^F0^FE^CA = C8
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    send_byte(8'hC8);
    idle(1);
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== '0 || wd_q[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reload_write: got writes %0d expected 1 at addr 0 data cafef00d", wa_q.size());
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_done: got done %b error %b busy %b expected 1 0 0", done, error, busy);
    end
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_gapped_words();
    test_length_limit();
    test_empty_and_bad_chk();
    test_abort_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
